char_rotator: RTL and testbench
===============================

# char_rotator

Upstream message stage for the seven-segment character decoders. Holds a small circular buffer of 3-bit character codes, rotates it one position every `TICK_DIV` clock cycles while enabled, and presents one 3-bit code per display digit. Each digit's code drives the 3-bit input of one downstream 7-segment character decoder. Slots can be rewritten at run time through a single-cycle write port.

## Interface
- `NUM_CHARS`, default 5: number of buffer slots and of display digits; valid range 2–8.
- `TICK_DIV`, default 50_000_000: clock cycles per rotation step; must be ≥1.
- `CLOCK_50` in, 1 bit: sole clock, rising edge.
- `RESETn` in, 1 bit: asynchronous, active-low reset.
- `run` in, 1 bit: 1 = prescaler counts and rotation advances; 0 = freeze.
- `wr_en` in, 1 bit: write strobe, sampled each rising edge.
- `wr_idx` in, 3 bits: physical slot to write.
- `wr_char` in, 3 bits: code to write.
- `char_out` out, `NUM_CHARS*3` bits: digit k's code on `char_out[3k+2:3k]`; k=0 is the rightmost digit (HEX0).
- `pos` out, 3 bits: current rotation offset, 0..`NUM_CHARS-1`.
- `tick` out, 1 bit: one-cycle pulse, high in the cycle after `pos` advances.

## Operation
- Code map, shared with the decoder: 000=H, 001=E, 010=L, 011=O, 1xx=blank. The decoder treats 100 as blank.
- Reset value of slot i is `RESET_MSG[i]`. For N=5: slot4..slot0 = H,E,L,L,O. For other N, slots ≥5 reset to 100.
- Reset state: `pos`=0, prescaler=0, `tick`=0, `char_out` = reset message with digit k = slot k.
- Prescaler:
  - When `run`=1, it increments each edge.
  - At value `TICK_DIV-1` it wraps to 0 on that edge, and the same edge does `pos` ← (`pos`+1) mod N and sets `tick` ← 1.
  - On every other edge, `tick` ← 0.
  - When `run`=0, the prescaler and `pos` hold their values (not cleared) and `tick` ← 0.
- Display mapping: digit k shows slot (k + N − `pos`) mod N. Content moves one digit left per step and wraps from the leftmost digit back to HEX0.
- Write: if `wr_en`=1 and `wr_idx` < N, then slot[`wr_idx`] ← `wr_char` on the edge. If `wr_idx` ≥ N, the write is ignored with no side effects.
  - Writes address physical slots and are independent of `pos` and `run`.
- Write and rotation on the same edge: both take effect. After the edge, `char_out` reflects both the new slot contents and the new `pos`.
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required. Operation resumes on the first edge after `RESETn` rises.

## Timing
- `char_out` is combinational from registered slots and `pos`. A write or rotation at edge t is visible on `char_out` after edge t (zero extra latency).
- `tick` is registered and high for exactly one cycle per step.
- `TICK_DIV`=1 with `run`=1 rotates on every edge and holds `tick` high continuously.
- First step after reset, or after resuming, occurs on the `TICK_DIV`-th rising edge with `run`=1, counted from prescaler 0.
- Prescaler width is clog2(`TICK_DIV`), minimum 1 bit. There is no overflow path.

## Structure
- Shared package `char_rot_pkg` holds:
  - character code constants `CH_H`, `CH_E`, `CH_L`, `CH_O`, `CH_BLANK`;
  - `RESET_MSG` array;
  - a `wrap_idx` function for the modulo-N slot mapping.
- Sub-module `tick_prescaler`, parameterized by `TICK_DIV`, with ports clock, reset, `run`, and `step` (combinational wrap indication).
- The rotator itself contains the slot registers, `pos`, the `tick` register, and the output mux.

## Test plan
- Reset check, `TICK_DIV`=4, `run`=0 for 20 cycles: `char_out` = {H,E,L,L,O} = 15'b000_001_010_010_011; `pos`=0; `tick` never high.
- `run`=1 from reset: `tick` pulses every 4 cycles. After the first step, digit0=H and digit4=E. After 5 steps, `pos`=0 and the output equals the reset pattern.
- Pause: drop `run` at prescaler=2, hold 10 cycles, then raise `run`. Next step occurs 2 cycles after re-enable; `pos` unchanged during the pause.
- Writes:
  - `wr_en`, `wr_idx`=0, `wr_char`=100 at `pos`=0: digit0 blank after that edge.
  - `wr_idx`=6: no change.
  - Write on the same edge as a rotation: `pos` advances and the new code appears at digit (0+`pos`) mod 5.
- Assert `RESETn`=0 mid-count at `pos`=3: outputs return to the reset pattern without a clock edge, and prescaler restart gives the first `tick` 4 edges after release.
- `TICK_DIV`=1, `run`=1: `tick` constant 1 and `pos` cycles 0,1,2,3,4,0 on consecutive edges.

Source files
------------

// File: rtl/char_rot_pkg.sv
// Shared character codes, reset message and slot-mapping helper for the rotator.
// Pure definitions: no latency, no flow control.
package char_rot_pkg;

  typedef logic [2:0] char_t;

  localparam char_t CH_H     = 3'b000;
  localparam char_t CH_E     = 3'b001;
  localparam char_t CH_L     = 3'b010;
  localparam char_t CH_O     = 3'b011;
  localparam char_t CH_BLANK = 3'b100;

  localparam int MAX_CHARS = 8;

  // Index 0 is the rightmost digit, so "HELLO" reads left to right on slots 4..0.
  localparam char_t RESET_MSG [0:MAX_CHARS-1] = '{
    CH_O, CH_L, CH_L, CH_E, CH_H, CH_BLANK, CH_BLANK, CH_BLANK
  };

  // Slot shown on digit k at rotation offset p: (k + n - p) mod n, with k, p < n.
  function automatic logic [2:0] wrap_idx(input logic [2:0] k, input logic [2:0] p,
                                          input int n);
    int s;
    s = int'(k) + n - int'(p);
    if (s >= n) s = s - n;
    return s[2:0];
  endfunction

endpackage

// File: rtl/char_rotator_if.sv
// Control/write/display bundle between the rotator and its driver.
// Plain wires: no latency, no backpressure.
interface char_rotator_if #(
  parameter int NUM_CHARS = 5
);
  logic                   run;
  logic                   wr_en;
  logic [2:0]             wr_idx;
  logic [2:0]             wr_char;
  logic [NUM_CHARS*3-1:0] char_out;
  logic [2:0]             pos;
  logic                   tick;

  modport master (
    output run, wr_en, wr_idx, wr_char,
    input  char_out, pos, tick
  );

  modport slave (
    input  run, wr_en, wr_idx, wr_char,
    output char_out, pos, tick
  );
endinterface

// File: rtl/char_rotator_tick_prescaler.sv
// Counts run-enabled cycles and flags the TICK_DIV-th one; step is combinational.
// Counter holds while run=0; no backpressure.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic step
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign step = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= step ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/char_rotator.sv
// Circular 3-bit character buffer rotated every TICK_DIV enabled cycles, one code per digit.
// char_out is zero-latency from registered state; tick is registered; no backpressure.
module char_rotator
  import char_rot_pkg::*;
#(
  parameter int NUM_CHARS = 5,
  parameter int TICK_DIV  = 50_000_000
) (
  input  logic           CLOCK_50,
  input  logic           RESETn,
  char_rotator_if.slave  bus
);
  char_t                  slot [NUM_CHARS];
  logic [2:0]             pos;
  logic                   tick;
  logic                   step;
  logic [NUM_CHARS*3-1:0] char_vec;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (CLOCK_50),
    .rst_n (RESETn),
    .run   (bus.run),
    .step  (step)
  );

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_CHARS; i++) slot[i] <= RESET_MSG[i];
      pos  <= '0;
      tick <= 1'b0;
    end else begin
      // Out-of-range indices match no slot, so they fall through untouched.
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (bus.wr_en && bus.wr_idx == 3'(i)) slot[i] <= bus.wr_char;
      end
      if (step) pos <= (pos == 3'(NUM_CHARS - 1)) ? 3'd0 : pos + 3'd1;
      tick <= step;
    end
  end

  always_comb begin
    char_vec = '0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      char_vec[3*k +: 3] = slot[wrap_idx(3'(k), pos, NUM_CHARS)];
    end
  end

  assign bus.char_out = char_vec;
  assign bus.pos      = pos;
  assign bus.tick     = tick;
endmodule

// File: tb/tb_char_rotator.sv
module tb_char_rotator;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  char_rotator_if #(.NUM_CHARS(5)) b4 ();
  char_rotator_if #(.NUM_CHARS(5)) b1 ();

  char_rotator #(.NUM_CHARS(5), .TICK_DIV(4)) dut4 (
    .CLOCK_50 (clk),
    .RESETn   (rst_n),
    .bus      (b4)
  );

  char_rotator #(.NUM_CHARS(5), .TICK_DIV(1)) dut1 (
    .CLOCK_50 (clk),
    .RESETn   (rst_n),
    .bus      (b1)
  );

  localparam logic [14:0] RESET_PAT = 15'b000_001_010_010_011;

  int tests = 0;
  int fails = 0;

  logic [2:0] m_slot [5];
  int         m_pos;
  int         m_cnt;
  logic       m_tick;

  typedef struct packed {
    logic [14:0] c;
    logic [2:0]  p;
    logic        t;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot[0] = 3'b011;
    m_slot[1] = 3'b010;
    m_slot[2] = 3'b010;
    m_slot[3] = 3'b001;
    m_slot[4] = 3'b000;
    m_pos  = 0;
    m_cnt  = 0;
    m_tick = 1'b0;
  endtask

  // Predict the edge from the currently driven inputs, then compare after it.
  task automatic step();
    exp_t e;
    exp_t x;
    if (b4.wr_en && b4.wr_idx < 3'd5) m_slot[b4.wr_idx] = b4.wr_char;
    if (b4.run) begin
      if (m_cnt == 3) begin
        m_cnt  = 0;
        m_pos  = (m_pos + 1) % 5;
        m_tick = 1'b1;
      end else begin
        m_cnt++;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    for (int k = 0; k < 5; k++) e.c[3*k +: 3] = m_slot[(k + 5 - m_pos) % 5];
    e.p = 3'(m_pos);
    e.t = m_tick;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("sb_char_out", 32'(b4.char_out), 32'(x.c));
    chk("sb_pos",      32'(b4.pos),      32'(x.p));
    chk("sb_tick",     32'(b4.tick),     32'(x.t));
  endtask

  initial begin
    b4.run = 1'b0; b4.wr_en = 1'b0; b4.wr_idx = 3'd0; b4.wr_char = 3'd0;
    b1.run = 1'b0; b1.wr_en = 1'b0; b1.wr_idx = 3'd0; b1.wr_char = 3'd0;
    model_reset();

    // Reset state, observed without any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_char_out", 32'(b4.char_out), 32'(RESET_PAT));
    chk("rst_pos",      32'(b4.pos),      32'd0);
    chk("rst_tick",     32'(b4.tick),     32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frozen for 20 cycles.
    for (int i = 0; i < 20; i++) step();
    chk("frozen_char_out", 32'(b4.char_out), 32'(RESET_PAT));

    // Run: first step on the 4th edge.
    b4.run = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("pre_step_tick", 32'(b4.tick), 32'd0);
    step();
    chk("first_step_tick",   32'(b4.tick),           32'd1);
    chk("first_step_digit0", 32'(b4.char_out[2:0]),   32'h0);
    chk("first_step_digit4", 32'(b4.char_out[14:12]), 32'h1);
    for (int i = 0; i < 16; i++) step();
    chk("full_turn_pos",      32'(b4.pos),      32'd0);
    chk("full_turn_char_out", 32'(b4.char_out), 32'(RESET_PAT));

    // Pause at prescaler=2, resume: step comes 2 edges later.
    step();
    step();
    b4.run = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("pause_pos", 32'(b4.pos), 32'd0);
    b4.run = 1'b1;
    step();
    chk("resume_tick_1", 32'(b4.tick), 32'd0);
    step();
    chk("resume_tick_2", 32'(b4.tick), 32'd1);
    chk("resume_pos",    32'(b4.pos),  32'd1);

    // Back to pos 0, then writes while frozen.
    for (int i = 0; i < 16; i++) step();
    b4.run = 1'b0;
    b4.wr_en = 1'b1; b4.wr_idx = 3'd0; b4.wr_char = 3'b100;
    step();
    chk("wr_digit0_blank", 32'(b4.char_out[2:0]), 32'h4);
    b4.wr_idx = 3'd6; b4.wr_char = 3'b001;
    step();
    b4.wr_en = 1'b0;

    // Write coinciding with a rotation.
    b4.run = 1'b1;
    for (int i = 0; i < 3; i++) step();
    b4.wr_en = 1'b1; b4.wr_idx = 3'd0; b4.wr_char = 3'b001;
    step();
    b4.wr_en = 1'b0;
    chk("wr_rot_pos",    32'(b4.pos),           32'd1);
    chk("wr_rot_digit1", 32'(b4.char_out[5:3]), 32'h1);

    // Async reset mid-count at pos 3.
    for (int i = 0; i < 10; i++) step();
    chk("pre_reset_pos", 32'(b4.pos), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("async_rst_char_out", 32'(b4.char_out), 32'(RESET_PAT));
    chk("async_rst_pos",      32'(b4.pos),      32'd0);
    chk("async_rst_tick",     32'(b4.tick),     32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_tick", 32'(b4.tick), (i == 3) ? 32'd1 : 32'd0);
    end
    b4.run = 1'b0;

    // TICK_DIV=1: rotate on every edge, tick held high.
    chk("div1_pos_start", 32'(b1.pos), 32'd0);
    b1.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("div1_pos",  32'(b1.pos),  32'((i + 1) % 5));
      chk("div1_tick", 32'(b1.tick), 32'd1);
    end
    b1.run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
